// File: rtl/axi_llc_tag_sweep_ctrl.sv
// rtl/axi_llc_tag_sweep_ctrl.sv - LLC tag SRAM port arbiter with sweep-based tag invalidation
// Optional feature macro: AXI_LLC_TAG_INIT_ON_RESET_EN (sweep all tags on reset exit).
module axi_llc_tag_sweep_ctrl #(
   parameter  int NumLines  = 256,
   parameter  int TagWidth  = 32,
   parameter  int Latency   = 1,
   localparam int AddrWidth = (NumLines > 1) ? $clog2(NumLines) : 1,
   localparam int BeWidth   = (TagWidth + 7) / 8
) (
   input  logic                 clk_i,
   input  logic                 rst_ni,
   input  logic                 flush_i,
   output logic                 busy_o,
   output logic                 done_o,
   input  logic                 lu_valid_i,
   output logic                 lu_ready_o,
   input  logic                 lu_we_i,
   input  logic [AddrWidth-1:0] lu_idx_i,
   input  logic [TagWidth-1:0]  lu_wdata_i,
   output logic                 lu_rvalid_o,
   output logic [TagWidth-1:0]  lu_rdata_o,
   output logic                 sram_req_o,
   output logic                 sram_we_o,
   output logic [AddrWidth-1:0] sram_addr_o,
   output logic [TagWidth-1:0]  sram_wdata_o,
   output logic [BeWidth-1:0]   sram_be_o,
   input  logic [TagWidth-1:0]  sram_rdata_i
);

   typedef enum logic {IDLE, SWEEP} state_e;

`ifdef AXI_LLC_TAG_INIT_ON_RESET_EN
   localparam state_e ResetState = SWEEP;
`else
   localparam state_e ResetState = IDLE;
`endif

   state_e               r_state, w_state_nxt;
   logic [AddrWidth-1:0] r_cnt, w_cnt_nxt;
   logic                 r_done, w_done_nxt;
   logic [Latency-1:0]   r_rd_pipe;
   logic                 w_hs;
   logic                 w_last;

   assign w_last = (r_cnt == AddrWidth'(NumLines - 1));

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_state   <= ResetState;
         r_cnt     <= '0;
         r_done    <= 1'b0;
         r_rd_pipe <= '0;
      end else begin
         r_state      <= w_state_nxt;
         r_cnt        <= w_cnt_nxt;
         r_done       <= w_done_nxt;
         r_rd_pipe[0] <= w_hs & ~lu_we_i;
         for (int i = 1; i < Latency; i++) begin
            r_rd_pipe[i] <= r_rd_pipe[i-1];
         end
      end
   end

   // SRAM-facing outputs are qualified by rst_ni so the port is quiet while held in reset,
   // even when the reset-exit state is SWEEP.
   always_comb begin
      w_state_nxt  = r_state;
      w_cnt_nxt    = r_cnt;
      w_done_nxt   = 1'b0;
      w_hs         = 1'b0;
      lu_ready_o   = 1'b0;
      sram_req_o   = 1'b0;
      sram_we_o    = 1'b0;
      sram_addr_o  = '0;
      sram_wdata_o = '0;
      case (r_state)
         IDLE: begin
            lu_ready_o = rst_ni;
            w_hs       = lu_valid_i & rst_ni;
            if (w_hs) begin
               sram_req_o   = 1'b1;
               sram_we_o    = lu_we_i;
               sram_addr_o  = lu_idx_i;
               sram_wdata_o = lu_wdata_i;
            end
            if (flush_i) begin
               w_state_nxt = SWEEP;
               w_cnt_nxt   = '0;
            end
         end
         SWEEP: begin
            sram_req_o  = rst_ni;
            sram_we_o   = rst_ni;
            sram_addr_o = rst_ni ? r_cnt : '0;
            if (w_last) begin
               w_state_nxt = IDLE;
               w_cnt_nxt   = '0;
               w_done_nxt  = 1'b1;
            end else begin
               w_cnt_nxt = r_cnt + AddrWidth'(1);
            end
         end
         default: begin
            w_state_nxt = IDLE;
         end
      endcase
   end

   assign busy_o      = (r_state == SWEEP);
   assign done_o      = r_done;
   assign lu_rvalid_o = r_rd_pipe[Latency-1];
   assign lu_rdata_o  = lu_rvalid_o ? sram_rdata_i : '0;
   assign sram_be_o   = '1;

endmodule

// File: tb/tb_axi_llc_tag_sweep_ctrl.sv
// tb/tb_axi_llc_tag_sweep_ctrl.sv - self-checking bench for axi_llc_tag_sweep_ctrl
// Uses a behavioural SRAM model and a read-response scoreboard.
module tb_axi_llc_tag_sweep_ctrl;

   localparam int NL  = 8;
   localparam int TW  = 32;
   localparam int LAT = 2;
   localparam int AW  = 3;
   localparam int BW  = 4;

   typedef struct {
      logic [TW-1:0] data;
      int            cyc;
   } rsp_t;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          flush_i = 1'b0;
   logic          busy_o, done_o;
   logic          lu_valid_i = 1'b0;
   logic          lu_ready_o;
   logic          lu_we_i = 1'b0;
   logic [AW-1:0] lu_idx_i = '0;
   logic [TW-1:0] lu_wdata_i = '0;
   logic          lu_rvalid_o;
   logic [TW-1:0] lu_rdata_o;
   logic          sram_req_o, sram_we_o;
   logic [AW-1:0] sram_addr_o;
   logic [TW-1:0] sram_wdata_o;
   logic [BW-1:0] sram_be_o;
   logic [TW-1:0] sram_rdata_i;

   int n_tests = 0;
   int n_fail  = 0;
   int cyc     = 0;
   rsp_t sb[$];
   logic [TW-1:0] exp_mem [NL];

   logic          mdl_init = 1'b1;
   logic [TW-1:0] mem     [NL];
   logic [TW-1:0] rd_pipe [LAT];

   axi_llc_tag_sweep_ctrl #(.NumLines(NL), .TagWidth(TW), .Latency(LAT)) dut (
      .clk_i(clk), .rst_ni(rst_n), .flush_i(flush_i), .busy_o(busy_o), .done_o(done_o),
      .lu_valid_i(lu_valid_i), .lu_ready_o(lu_ready_o), .lu_we_i(lu_we_i),
      .lu_idx_i(lu_idx_i), .lu_wdata_i(lu_wdata_i), .lu_rvalid_o(lu_rvalid_o),
      .lu_rdata_o(lu_rdata_o), .sram_req_o(sram_req_o), .sram_we_o(sram_we_o),
      .sram_addr_o(sram_addr_o), .sram_wdata_o(sram_wdata_o), .sram_be_o(sram_be_o),
      .sram_rdata_i(sram_rdata_i)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // SRAM model: write on posedge, read data emerges LAT cycles after the request cycle
   always @(posedge clk) begin
      if (mdl_init) begin
         for (int i = 0; i < NL; i++) mem[i] <= 32'hCAFE_0000 | i;
      end else if (sram_req_o && sram_we_o) begin
         mem[sram_addr_o] <= sram_wdata_o;
      end
      rd_pipe[0] <= (sram_req_o && !sram_we_o) ? mem[sram_addr_o] : 32'hDEAD_BEEF;
      for (int i = 1; i < LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
   end
   assign sram_rdata_i = rd_pipe[LAT-1];

   always @(negedge clk) begin
      if (lu_rvalid_o === 1'b1) begin
         n_tests++;
         if (sb.size() == 0) begin
            n_fail++;
            $display("FAIL rsp_unexpected: rvalid=1 rdata=%h at cyc %0d, required no response", lu_rdata_o, cyc);
         end else begin
            rsp_t e;
            e = sb.pop_front();
            if (lu_rdata_o !== e.data || cyc != e.cyc) begin
               n_fail++;
               $display("FAIL rsp_data: rdata=%h cyc=%0d, required rdata=%h cyc=%0d", lu_rdata_o, cyc, e.data, e.cyc);
            end
         end
      end else if (lu_rdata_o !== '0) begin
         n_tests++;
         n_fail++;
         $display("FAIL rdata_idle: rdata=%h while rvalid=0, required 0", lu_rdata_o);
      end
   end

   task automatic drive_lookup(input logic we, input int idx, input logic [TW-1:0] wd);
      lu_valid_i = 1'b1; lu_we_i = we; lu_idx_i = AW'(idx); lu_wdata_i = wd;
      @(negedge clk);
      if (!we) sb.push_back('{exp_mem[idx], cyc + LAT});
      else exp_mem[idx] = wd;
      @(posedge clk); #1;
      lu_valid_i = 1'b0; lu_we_i = 1'b0;
   endtask

   task automatic wait_after_reset_release();
`ifdef AXI_LLC_TAG_INIT_ON_RESET_EN
      repeat (NL + 2) @(negedge clk);
      for (int i = 0; i < NL; i++) exp_mem[i] = '0;
`endif
      @(posedge clk); #1;
   endtask

   task automatic test_reset();
      repeat (3) @(posedge clk);
      mdl_init = 1'b0;
      @(negedge clk);
      n_tests++;
      if (lu_ready_o !== 1'b0 || sram_req_o !== 1'b0 || done_o !== 1'b0 || lu_rvalid_o !== 1'b0 || sram_be_o !== 4'hF) begin
         n_fail++;
         $display("FAIL reset_outputs: ready=%b req=%b done=%b rvalid=%b be=%h, required 0 0 0 0 f",
                  lu_ready_o, sram_req_o, done_o, lu_rvalid_o, sram_be_o);
      end
      n_tests++;
`ifdef AXI_LLC_TAG_INIT_ON_RESET_EN
      if (busy_o !== 1'b1) begin n_fail++; $display("FAIL reset_busy: busy=%b, required 1", busy_o); end
`else
      if (busy_o !== 1'b0) begin n_fail++; $display("FAIL reset_busy: busy=%b, required 0", busy_o); end
`endif
      rst_n = 1'b1;
      wait_after_reset_release();
      @(negedge clk);
      n_tests++;
      if (lu_ready_o !== 1'b1 || busy_o !== 1'b0 || sram_req_o !== 1'b0) begin
         n_fail++;
         $display("FAIL post_reset_idle: ready=%b busy=%b req=%b, required 1 0 0", lu_ready_o, busy_o, sram_req_o);
      end
      @(posedge clk); #1;
   endtask

   task automatic test_read_latency();
      drive_lookup(1'b0, 5, '0);
      repeat (LAT + 1) @(posedge clk);
      #1;
   endtask

   task automatic test_write_read();
      drive_lookup(1'b1, 2, 32'h55AA_1234);
      drive_lookup(1'b0, 2, '0);
      drive_lookup(1'b1, 7, 32'h0BAD_F00D);
      drive_lookup(1'b0, 7, '0);
      repeat (LAT + 1) @(posedge clk);
      #1;
   endtask

   task automatic test_back_to_back();
      for (int i = 0; i < NL; i++) drive_lookup(1'b0, i, '0);
      repeat (LAT + 1) @(posedge clk);
      #1;
   endtask

   task automatic test_flush_with_lookup();
      int dones;
      flush_i = 1'b1; lu_valid_i = 1'b1; lu_we_i = 1'b1; lu_idx_i = 3'd3; lu_wdata_i = 32'h1234;
      @(negedge clk);
      n_tests++;
      if (sram_req_o !== 1'b1 || sram_we_o !== 1'b1 || sram_addr_o !== 3'd3 || sram_wdata_o !== 32'h1234 || lu_ready_o !== 1'b1) begin
         n_fail++;
         $display("FAIL flush_lookup_cycle: req=%b we=%b addr=%0d wdata=%h ready=%b, required 1 1 3 00001234 1",
                  sram_req_o, sram_we_o, sram_addr_o, sram_wdata_o, lu_ready_o);
      end
      @(posedge clk); #1;
      flush_i = 1'b0; lu_valid_i = 1'b0; lu_we_i = 1'b0;
      dones = 0;
      for (int i = 0; i < NL; i++) begin
         @(negedge clk);
         if (done_o === 1'b1) dones++;
         n_tests++;
         if (sram_req_o !== 1'b1 || sram_we_o !== 1'b1 || sram_addr_o !== AW'(i) || sram_wdata_o !== '0 || lu_ready_o !== 1'b0 || busy_o !== 1'b1) begin
            n_fail++;
            $display("FAIL sweep_a[%0d]: req=%b we=%b addr=%0d wdata=%h ready=%b busy=%b, required 1 1 %0d 0 0 1",
                     i, sram_req_o, sram_we_o, sram_addr_o, sram_wdata_o, lu_ready_o, busy_o, i);
         end
      end
      @(negedge clk);
      n_tests++;
      if (done_o !== 1'b1 || busy_o !== 1'b0 || lu_ready_o !== 1'b1 || dones != 0) begin
         n_fail++;
         $display("FAIL sweep_a_done: done=%b busy=%b ready=%b early_dones=%0d, required 1 0 1 0", done_o, busy_o, lu_ready_o, dones);
      end
      for (int i = 0; i < NL; i++) exp_mem[i] = '0;
      @(posedge clk); #1;
      drive_lookup(1'b0, 3, '0);
      repeat (LAT + 1) @(posedge clk);
      #1;
   endtask

   task automatic test_flush_inflight();
      drive_lookup(1'b1, 1, 32'h1111_1111);
      drive_lookup(1'b1, 2, 32'h2222_2222);
      drive_lookup(1'b0, 1, '0);
      drive_lookup(1'b0, 2, '0);
      flush_i = 1'b1;
      @(posedge clk); #1;
      flush_i = 1'b0;
      for (int i = 0; i < NL; i++) begin
         @(negedge clk);
         n_tests++;
         if (sram_req_o !== 1'b1 || sram_we_o !== 1'b1 || sram_addr_o !== AW'(i) || sram_wdata_o !== '0) begin
            n_fail++;
            $display("FAIL sweep_b[%0d]: req=%b we=%b addr=%0d wdata=%h, required 1 1 %0d 0",
                     i, sram_req_o, sram_we_o, sram_addr_o, sram_wdata_o, i);
         end
      end
      @(negedge clk);
      n_tests++;
      if (done_o !== 1'b1 || sb.size() != 0) begin
         n_fail++;
         $display("FAIL sweep_b_done: done=%b pending_rsp=%0d, required 1 0", done_o, sb.size());
      end
      for (int i = 0; i < NL; i++) exp_mem[i] = '0;
      @(posedge clk); #1;
   endtask

   task automatic test_flush_mid_sweep();
      int dones;
      int sweep_cycles;
      flush_i = 1'b1;
      @(posedge clk); #1;
      flush_i = 1'b0;
      dones = 0;
      sweep_cycles = 0;
      for (int i = 0; i < NL + 6; i++) begin
         @(negedge clk);
         if (busy_o === 1'b1) sweep_cycles++;
         if (done_o === 1'b1) dones++;
         flush_i = (i == 2) || (i == NL - 1);
      end
      flush_i = 1'b0;
      n_tests++;
      if (sweep_cycles != NL || dones != 1) begin
         n_fail++;
         $display("FAIL flush_mid_sweep: busy_cycles=%0d done_pulses=%0d, required %0d 1", sweep_cycles, dones, NL);
      end
      @(posedge clk); #1;
   endtask

   task automatic test_reset_mid_sweep();
      int guard;
      drive_lookup(1'b0, 6, '0);
      @(negedge clk);
      rst_n = 1'b0;
      sb.delete();
      #1;
      n_tests++;
      if (lu_rvalid_o !== 1'b0 || sram_req_o !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_inflight: rvalid=%b req=%b, required 0 0", lu_rvalid_o, sram_req_o);
      end
      @(negedge clk);
      rst_n = 1'b1;
      wait_after_reset_release();
      repeat (LAT + 4) @(posedge clk);
      #1;
      flush_i = 1'b1;
      @(posedge clk); #1;
      flush_i = 1'b0;
      guard = 0;
      @(negedge clk);
      while (sram_addr_o !== 3'd4 && guard < NL) begin
         @(negedge clk);
         guard++;
      end
      n_tests++;
      if (sram_addr_o !== 3'd4 || busy_o !== 1'b1) begin
         n_fail++;
         $display("FAIL reach_cnt4: addr=%0d busy=%b, required 4 1", sram_addr_o, busy_o);
      end
      rst_n = 1'b0;
      #1;
      n_tests++;
      if (sram_req_o !== 1'b0 || sram_we_o !== 1'b0 || sram_addr_o !== '0 || lu_ready_o !== 1'b0 || done_o !== 1'b0 || sram_be_o !== 4'hF) begin
         n_fail++;
         $display("FAIL reset_mid_sweep: req=%b we=%b addr=%0d ready=%b done=%b be=%h, required 0 0 0 0 0 f",
                  sram_req_o, sram_we_o, sram_addr_o, lu_ready_o, done_o, sram_be_o);
      end
`ifndef AXI_LLC_TAG_INIT_ON_RESET_EN
      n_tests++;
      if (busy_o !== 1'b0) begin n_fail++; $display("FAIL reset_mid_sweep_busy: busy=%b, required 0", busy_o); end
`endif
      @(negedge clk);
      rst_n = 1'b1;
      wait_after_reset_release();
      @(negedge clk);
      n_tests++;
      if (lu_ready_o !== 1'b1 || busy_o !== 1'b0 || sram_req_o !== 1'b0 || done_o !== 1'b0) begin
         n_fail++;
         $display("FAIL post_reset_mid_sweep: ready=%b busy=%b req=%b done=%b, required 1 0 0 0", lu_ready_o, busy_o, sram_req_o, done_o);
      end
      @(posedge clk); #1;
      drive_lookup(1'b0, 5, '0);
      repeat (LAT + 1) @(posedge clk);
      #1;
   endtask

   initial begin
      for (int i = 0; i < NL; i++) exp_mem[i] = 32'hCAFE_0000 | i;
      test_reset();
      test_read_latency();
      test_write_read();
      test_back_to_back();
      test_flush_with_lookup();
      test_flush_inflight();
      test_flush_mid_sweep();
      test_reset_mid_sweep();
      n_tests++;
      if (sb.size() != 0) begin
         n_fail++;
         $display("FAIL rsp_missing: %0d responses outstanding, required 0", sb.size());
      end
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/axi_llc_tag_sweep_ctrl.md
Name: axi_llc_tag_sweep_ctrl

Overview:
- Sequencer and single-port arbiter in front of one LLC tag SRAM port (req/we/addr/wdata/be, fixed-latency rdata).
- Shares the port between the lookup requester (tag read/update from the LLC pipeline) and an internal sweep engine.
- The sweep engine writes the init pattern (all-zero: invalid, clean) to every tag index after reset or on flush command.
- While a sweep runs, lookups are stalled.

Parameters:
NumLines, 256, number of tag entries (SRAM words); >= 1
TagWidth, 32, tag word width in bits
Latency, 1, SRAM read latency in cycles; >= 1
AddrWidth, (NumLines > 1) ? $clog2(NumLines) : 1, derived, do not override

Ports:
clk_i  in  1  clock
rst_ni  in  1  asynchronous reset, active low
flush_i  in  1  pulse: request a full sweep
busy_o  out  1  sweep in progress
done_o  out  1  one-cycle pulse after last sweep write
lu_valid_i  in  1  lookup request valid
lu_ready_o  out  1  lookup request accepted
lu_we_i  in  1  1 = write tag, 0 = read tag
lu_idx_i  in  AddrWidth  tag index
lu_wdata_i  in  TagWidth  write tag data
lu_rvalid_o  out  1  read data valid (no backpressure)
lu_rdata_o  out  TagWidth  read data
sram_req_o  out  1  SRAM request
sram_we_o  out  1  SRAM write enable
sram_addr_o  out  AddrWidth  SRAM address
sram_wdata_o  out  TagWidth  SRAM write data
sram_be_o  out  ceil(TagWidth/8)  byte enable, always all-ones
sram_rdata_i  in  TagWidth  SRAM read data, valid Latency cycles after read req

Behaviour:
- Clock and reset: one clock clk_i; reset rst_ni is asynchronous, active low.
- Reset values: all outputs 0 (except sram_be_o = '1); sweep counter 0; read-latency shift register cleared.
- FSM states: IDLE and SWEEP.
  - Reset-exit state depends on the optional feature.
- IDLE:
  - lu_ready_o = 1 combinationally.
  - A handshake (lu_valid_i & lu_ready_o) drives the SRAM in the same cycle: sram_req_o = 1, sram_we_o = lu_we_i, addr = lu_idx_i, wdata = lu_wdata_i.
  - No handshake: sram_req_o = 0.
- IDLE -> SWEEP on flush_i.
  - If a lookup is also handshaken that cycle, the lookup is served in that cycle and the sweep starts next cycle.
  - Counter loads 0.
- SWEEP:
  - lu_ready_o = 0; busy_o = 1.
  - Each cycle: sram_req_o = 1, sram_we_o = 1, addr = counter, wdata = '0; counter increments.
  - After the write to index NumLines-1: next state IDLE, done_o = 1 for exactly one cycle (first IDLE cycle), busy_o = 0.
  - Sweep length is exactly NumLines cycles; NumLines = 1 gives a one-cycle sweep.
  - Counter never wraps past NumLines-1.
- flush_i during SWEEP: ignored; no restart, no queueing.
- Read response:
  - Each accepted lookup read (lu_we_i = 0) pushes a 1 into a Latency-deep shift register.
  - lu_rvalid_o pulses exactly Latency cycles after acceptance; lu_rdata_o = sram_rdata_i while lu_rvalid_o = 1, else 0.
  - Writes and sweep writes produce no response.
- In-flight reads at flush time still complete with correct data; a sweep write never overtakes an earlier read.
- Back-to-back reads: one per cycle; responses in order, one per cycle.
- Reset mid-sweep or with reads in flight: all state dropped immediately; no stray lu_rvalid_o after reset release.

Optional Feature:
- Macro: AXI_LLC_TAG_INIT_ON_RESET_EN.
- Defined: reset-exit state is SWEEP. The first NumLines cycles after reset release invalidate all tags, then done_o pulses. busy_o = 1 during reset, so lookups are blocked from reset.
- Undefined: reset-exit state is IDLE with busy_o = 0. Tags stay uninitialised until the first flush_i.

Test Plan:
- Init on reset (macro defined, NumLines = 8): release reset -> 8 cycles of sram writes to addr 0..7 with wdata 0; lu_ready_o = 0 throughout; done_o pulses once in cycle 9; lu_ready_o = 1 afterwards.
- Read latency (Latency = 2): read idx 5 with sram_rdata_i returning 0xCAFE0005 -> lu_rvalid_o high exactly 2 cycles after the handshake, lu_rdata_o = 0xCAFE0005.
- Simultaneous flush and lookup: in IDLE, flush_i together with a write to idx 3 of 0x1234 -> that cycle writes 0x1234 to addr 3; next cycle sweep starts at addr 0; after the sweep, reading idx 3 returns 0.
- Flush with reads in flight (Latency = 3): reads to idx 1 and 2 back-to-back, then flush_i -> both lu_rvalid_o pulses occur with pre-sweep data; sweep proceeds unaffected.
- flush_i pulsed mid-sweep -> no restart; total sweep stays NumLines cycles; done_o pulses once.
- Reset asserted mid-sweep at counter 4 -> outputs 0 immediately; after release, behaviour matches reset-exit state; no lu_rvalid_o.
